// File: rtl/normaliser_shift_stage.sv
// normaliser_shift_stage: two-stage pipelined left shift that puts the leading one in the MSB,
// lowering the exponent by the same amount and clamping the shift at exponent 0.
module normaliser_shift_stage #(
   parameter int IN_SIZE  = 50,
   parameter int POS_SIZE = $clog2(IN_SIZE),
   parameter int EXP_SIZE = 11
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_SIZE-1:0]  in_mant,
   input  logic [EXP_SIZE-1:0] in_exp,
   input  logic [POS_SIZE-1:0] in_leading_pos,
   input  logic                in_zero,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [IN_SIZE-1:0]  out_mant,
   output logic [EXP_SIZE-1:0] out_exp,
   output logic                out_zero,
   output logic                out_underflow
);
   localparam int PW = POS_SIZE + 1;
   localparam int CW = (PW > EXP_SIZE) ? PW : EXP_SIZE;
   logic [PW-1:0]       w_pos, w_sh_req, w_sh;
   logic [EXP_SIZE-1:0] w_exp;
   logic                w_uf, w_adv_a, w_adv_b;
   logic                r_a_valid, r_a_zero, r_a_uf, r_b_valid, r_b_zero, r_b_uf;
   logic [IN_SIZE-1:0]  r_a_mant, r_b_mant;
   logic [EXP_SIZE-1:0] r_a_exp, r_b_exp;
   logic [PW-1:0]       r_a_sh;
   assign w_pos    = {1'b0, in_leading_pos};
   // out-of-range positions are treated as an unshifted beat
   assign w_sh_req = (w_pos >= PW'(IN_SIZE)) ? '0 : PW'(IN_SIZE - 1) - w_pos;
   assign w_uf     = ~in_zero & (CW'(w_sh_req) > CW'(in_exp));
   assign w_sh     = in_zero ? '0 : w_uf ? PW'(in_exp) : w_sh_req;
   assign w_exp    = (in_zero | w_uf) ? '0 : in_exp - EXP_SIZE'(w_sh_req);
   assign w_adv_b  = ~r_b_valid | out_ready;
   assign w_adv_a  = ~r_a_valid | w_adv_b;
   assign in_ready = w_adv_a;
   always_ff @(posedge clk) begin
      if (w_adv_a && in_valid) begin
         r_a_mant <= in_zero ? '0 : in_mant;
         r_a_exp  <= w_exp;
         r_a_sh   <= w_sh;
         r_a_zero <= in_zero;
         r_a_uf   <= w_uf;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a_valid <= 1'b0;
         r_b_valid <= 1'b0;
         r_b_mant  <= '0;
         r_b_exp   <= '0;
         r_b_zero  <= 1'b0;
         r_b_uf    <= 1'b0;
      end else begin
         if (w_adv_a) r_a_valid <= in_valid;
         if (w_adv_b) r_b_valid <= r_a_valid;
         if (w_adv_b && r_a_valid) begin
            r_b_mant <= r_a_mant << r_a_sh;
            r_b_exp  <= r_a_exp;
            r_b_zero <= r_a_zero;
            r_b_uf   <= r_a_uf;
         end
      end
   end
   assign out_valid     = r_b_valid;
   assign out_mant      = r_b_mant;
   assign out_exp       = r_b_exp;
   assign out_zero      = r_b_zero;
   assign out_underflow = r_b_uf;
endmodule

// File: tb/tb_normaliser_shift_stage.sv
// tb_normaliser_shift_stage: directed scenarios with hand-computed results for the normalisation shifter.
module tb_normaliser_shift_stage;
   localparam int N = 50;
   localparam int P = 6;
   localparam int E = 11;
   localparam logic [N-1:0] ONE = 1;
   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, in_zero, out_valid, out_ready, out_zero, out_underflow;
   logic [N-1:0] in_mant, out_mant;
   logic [E-1:0] in_exp, out_exp;
   logic [P-1:0] in_leading_pos;
   int           n_cmp = 0;
   int           n_err = 0;
   normaliser_shift_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mant(in_mant), .in_exp(in_exp), .in_leading_pos(in_leading_pos), .in_zero(in_zero),
      .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
      .out_zero(out_zero), .out_underflow(out_underflow)
   );
   always #5 clk = ~clk;
   task automatic set_beat(input logic [N-1:0] m, input int e, input int p, input logic z);
      in_mant = m; in_exp = E'(e); in_leading_pos = P'(p); in_zero = z;
   endtask
   task automatic drive_one(input logic [N-1:0] m, input int e, input int p, input logic z);
      set_beat(m, e, p, z); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
   endtask
   task automatic test_reset;
      rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
      set_beat(ONE << 40, 100, 40, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_cmp++; if ({out_valid, out_mant, out_exp, out_zero, out_underflow} !== 64'd0) begin
         n_err++; $display("FAIL reset_outputs got %h want 0", {out_valid, out_mant, out_exp, out_zero, out_underflow});
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      rst_n = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
   endtask
   task automatic test_normal;
      logic [63:0] want;
      set_beat(ONE << 40, 100, 40, 1'b0); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL normal_latency got %b want 0", out_valid); end
      @(posedge clk); #1;
      want = {1'b1, ONE << 49, 11'd91, 1'b0, 1'b0};
      n_cmp++; if ({out_valid, out_mant, out_exp, out_zero, out_underflow} !== want) begin
         n_err++; $display("FAIL normal_shift got %h want %h", {out_valid, out_mant, out_exp, out_zero, out_underflow}, want);
      end
   endtask
   task automatic test_underflow;
      logic [63:0] want;
      drive_one((ONE << 10) | ONE, 5, 10, 1'b0);
      want = {1'b1, (ONE << 15) | (ONE << 5), 11'd0, 1'b0, 1'b1};
      n_cmp++; if ({out_valid, out_mant, out_exp, out_zero, out_underflow} !== want) begin
         n_err++; $display("FAIL underflow_clamp got %h want %h", {out_valid, out_mant, out_exp, out_zero, out_underflow}, want);
      end
      drive_one((ONE << 10) | ONE, 39, 10, 1'b0);
      want = {1'b1, (ONE << 49) | (ONE << 39), 11'd0, 1'b0, 1'b0};
      n_cmp++; if ({out_valid, out_mant, out_exp, out_zero, out_underflow} !== want) begin
         n_err++; $display("FAIL underflow_equal got %h want %h", {out_valid, out_mant, out_exp, out_zero, out_underflow}, want);
      end
      drive_one((ONE << 10) | ONE, 38, 10, 1'b0);
      want = {1'b1, (ONE << 48) | (ONE << 38), 11'd0, 1'b0, 1'b1};
      n_cmp++; if ({out_valid, out_mant, out_exp, out_zero, out_underflow} !== want) begin
         n_err++; $display("FAIL underflow_by_one got %h want %h", {out_valid, out_mant, out_exp, out_zero, out_underflow}, want);
      end
   endtask
   task automatic test_zero;
      logic [63:0] want;
      drive_one('0, 300, 49, 1'b1);
      want = {1'b1, 50'd0, 11'd0, 1'b1, 1'b0};
      n_cmp++; if ({out_valid, out_mant, out_exp, out_zero, out_underflow} !== want) begin
         n_err++; $display("FAIL zero_input got %h want %h", {out_valid, out_mant, out_exp, out_zero, out_underflow}, want);
      end
   endtask
   task automatic test_normalised;
      logic [63:0] want;
      drive_one((ONE << 49) | (ONE << 5), 0, 49, 1'b0);
      want = {1'b1, (ONE << 49) | (ONE << 5), 11'd0, 1'b0, 1'b0};
      n_cmp++; if ({out_valid, out_mant, out_exp, out_zero, out_underflow} !== want) begin
         n_err++; $display("FAIL already_normalised got %h want %h", {out_valid, out_mant, out_exp, out_zero, out_underflow}, want);
      end
      drive_one((ONE << 48) | ONE, 0, 48, 1'b0);
      want = {1'b1, (ONE << 48) | ONE, 11'd0, 1'b0, 1'b1};
      n_cmp++; if ({out_valid, out_mant, out_exp, out_zero, out_underflow} !== want) begin
         n_err++; $display("FAIL exp0_clamp got %h want %h", {out_valid, out_mant, out_exp, out_zero, out_underflow}, want);
      end
   endtask
   task automatic test_back_to_back;
      logic [N-1:0] bm[3], em[3];
      int           be[3], bp[3], ee[3];
      logic         bz[3], eu[3];
      bm[0] = ONE << 20;         be[0] = 50; bp[0] = 20; bz[0] = 1'b0; em[0] = ONE << 49;                 ee[0] = 21; eu[0] = 1'b0;
      bm[1] = '0;                be[1] = 7;  bp[1] = 49; bz[1] = 1'b1; em[1] = '0;                        ee[1] = 0;  eu[1] = 1'b0;
      bm[2] = (ONE << 3) | ONE;  be[2] = 2;  bp[2] = 3;  bz[2] = 1'b0; em[2] = (ONE << 5) | (ONE << 2);   ee[2] = 0;  eu[2] = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_valid = (c < 3);
         if (c < 3) set_beat(bm[c], be[c], bp[c], bz[c]);
         #1;
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", c, in_ready); end
         @(posedge clk); #1;
         n_cmp++; if (out_valid !== (c >= 1 && c <= 3)) begin
            n_err++; $display("FAIL b2b_valid cycle %0d got %b want %b", c, out_valid, (c >= 1 && c <= 3));
         end
         if (c >= 1 && c <= 3) begin
            n_cmp++; if ({out_mant, out_exp, out_zero, out_underflow} !== {em[c-1], E'(ee[c-1]), bz[c-1], eu[c-1]}) begin
               n_err++; $display("FAIL b2b_data beat %0d got %h want %h", c - 1, {out_mant, out_exp, out_zero, out_underflow},
                                 {em[c-1], E'(ee[c-1]), bz[c-1], eu[c-1]});
            end
         end
      end
      in_valid = 1'b0;
   endtask
   task automatic test_backpressure;
      logic [N-1:0] bm[5], em[5];
      int           be[5], bp[5], ee[5];
      int           sent = 0, recv = 0, occ = 0, first = -1, last = -1;
      logic         held = 1'b0, exp_rdy;
      logic [63:0]  obs, hold_t;
      for (int k = 0; k < 5; k++) begin
         bm[k] = (ONE << (40 - k)) | ONE; bp[k] = 40 - k; be[k] = 200 + 10 * k;
         em[k] = (ONE << 49) | (ONE << (9 + k)); ee[k] = 191 + 9 * k;
      end
      for (int c = 1; c <= 30 && recv < 5; c++) begin
         out_ready = !(c >= 2 && c <= 6);
         in_valid = (sent < 5);
         if (sent < 5) set_beat(bm[sent], be[sent], bp[sent], 1'b0);
         #1;
         obs = {out_valid, out_mant, out_exp, out_zero, out_underflow};
         exp_rdy = (occ < 2) || out_ready;
         n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL bp_in_ready cycle %0d got %b want %b", c, in_ready, exp_rdy); end
         if (held) begin
            n_cmp++; if (obs !== hold_t) begin n_err++; $display("FAIL bp_stable cycle %0d got %h want %h", c, obs, hold_t); end
         end
         held = out_valid && !out_ready;
         hold_t = obs;
         if (out_valid && out_ready) begin
            n_cmp++; if ({out_mant, out_exp, out_zero, out_underflow} !== {em[recv], E'(ee[recv]), 1'b0, 1'b0}) begin
               n_err++; $display("FAIL bp_order beat %0d got %h want %h", recv, {out_mant, out_exp, out_zero, out_underflow},
                                 {em[recv], E'(ee[recv]), 1'b0, 1'b0});
            end
            if (first < 0) first = c;
            last = c; recv++; occ--;
         end
         if (in_valid && in_ready) begin sent++; occ++; end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++; if (recv != 5) begin n_err++; $display("FAIL bp_count got %0d want 5", recv); end
      n_cmp++; if (last - first != 4) begin n_err++; $display("FAIL bp_rate got span %0d want 4", last - first); end
      @(posedge clk); #1;
   endtask
   task automatic test_reset_midflight;
      logic [63:0] want;
      out_ready = 1'b1; in_valid = 1'b1;
      set_beat(ONE << 30, 80, 30, 1'b0);
      @(posedge clk); #1;
      set_beat(ONE << 45, 10, 45, 1'b0);
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
      rst_n = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if ({out_valid, out_mant, out_exp, out_zero, out_underflow} !== 64'd0) begin
         n_err++; $display("FAIL rst_flush got %h want 0", {out_valid, out_mant, out_exp, out_zero, out_underflow});
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_ghost cycle %0d got %b want 0", c, out_valid); end
      end
      set_beat((ONE << 49) | ONE, 33, 49, 1'b0); in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_latency got %b want 0", out_valid); end
      @(posedge clk); #1;
      want = {1'b1, (ONE << 49) | ONE, 11'd33, 1'b0, 1'b0};
      n_cmp++; if ({out_valid, out_mant, out_exp, out_zero, out_underflow} !== want) begin
         n_err++; $display("FAIL rst_next_beat got %h want %h", {out_valid, out_mant, out_exp, out_zero, out_underflow}, want);
      end
   endtask
   initial begin
      test_reset;
      test_normal;
      test_underflow;
      test_zero;
      test_normalised;
      test_back_to_back;
      test_backpressure;
      test_reset_midflight;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
